// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared CPU decode constants. Holds the opcodes, the aluOp
//            encodings and the control-bit bundle used by the ID/EX register
//            and the EX-stage ALU control decoder.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // aluOp codes consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Memory / writeback / branch controls carried down the pipe
    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic branch;
    } ctrl_t;

    // Opcodes that read the rt register as a source operand
    function automatic logic op_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_unit
//  Purpose : Combinational load-use compare. Flags when the load sitting in
//            ID/EX writes a register the ID instruction is about to read.
//  Ports   : ex_valid_i, ex_memRead_i, ex_writeReg_i  - ID/EX register state
//            rs_i, rt_i, rtIsSrc_i, instrValid_i       - ID instruction
//            hazard_o                                  - stall request
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_memRead_i,
    input  logic [REG_AW-1:0] ex_writeReg_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              rtIsSrc_i,
    input  logic              instrValid_i,
    output logic              hazard_o
);

    logic w_rsMatch;
    logic w_rtMatch;

    assign w_rsMatch = (ex_writeReg_i == rs_i);
    assign w_rtMatch = (ex_writeReg_i == rt_i) & rtIsSrc_i;

    // $0 never carries a dependency, so a load into $0 cannot stall
    assign hazard_o = ex_valid_i & ex_memRead_i & (ex_writeReg_i != '0)
                    & (w_rsMatch | w_rtMatch) & instrValid_i;

endmodule
`default_nettype wire

// File: rtl/id_ex_decode.sv
`default_nettype none
// ============================================================================
//  Module  : id_ex_decode
//  Purpose : Decodes the ID-stage instruction (R-type, lw, sw, beq, addi),
//            selects ALU operands and controls, and registers them into the
//            ID/EX pipeline register. Inserts bubbles on flush, load-use
//            hazard, bubble input and illegal opcodes; holds on exHold.
//  Config  : HAZARD_DETECT_EN - when defined, load-use hazard detection is
//            built in (hazard_unit). Otherwise stallOut = exHold only.
//  Ports   : clk, reset (async, active-high)
//            instr, instrValid, rsData, rtData, flush, exHold - ID inputs
//            stallOut                 - IF/ID hold request (combinational)
//            ex_*                     - ID/EX register contents
//            illegalCount             - saturating illegal-opcode count
//  Rev     : 1.0  initial release
// ============================================================================
module id_ex_decode
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  instrValid,
    input  logic [DATA_WIDTH-1:0] rsData,
    input  logic [DATA_WIDTH-1:0] rtData,
    input  logic                  flush,
    input  logic                  exHold,
    output logic                  stallOut,
    output logic                  ex_valid,
    output logic [1:0]            ex_aluOp,
    output logic [5:0]            ex_function_code,
    output logic [DATA_WIDTH-1:0] ex_in1,
    output logic [DATA_WIDTH-1:0] ex_in2,
    output logic [DATA_WIDTH-1:0] ex_storeData,
    output logic [REG_AW-1:0]     ex_writeReg,
    output logic                  ex_regWrite,
    output logic                  ex_memRead,
    output logic                  ex_memWrite,
    output logic                  ex_memToReg,
    output logic                  ex_branch,
    output logic [ILL_CNT_W-1:0]  illegalCount
);

    typedef struct packed {
        logic                  valid;
        logic [1:0]            aluOp;
        logic [5:0]            funct;
        logic [DATA_WIDTH-1:0] in1;
        logic [DATA_WIDTH-1:0] in2;
        logic [DATA_WIDTH-1:0] storeData;
        logic [REG_AW-1:0]     writeReg;
        ctrl_t                 ctrl;
    } ex_t;

    ex_t                  ex_q,     ex_d;
    logic [ILL_CNT_W-1:0] illCnt_q, illCnt_d;

    logic [5:0]            w_op;
    logic [DATA_WIDTH-1:0] w_imm;
    ex_t                   w_dec;
    logic                  w_legal;
    logic                  w_hazard;
    logic                  w_consume;

    assign w_op  = instr[31:26];
    assign w_imm = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec       = '0;
        w_legal     = 1'b1;
        w_dec.valid = 1'b1;
        w_dec.in1   = rsData;
        w_dec.aluOp = ALUOP_ADD;
        case (w_op)
            OP_RTYPE: begin
                w_dec.aluOp         = ALUOP_FUNCT;
                w_dec.funct         = instr[5:0];
                w_dec.in2           = rtData;
                w_dec.writeReg      = REG_AW'(instr[15:11]);
                w_dec.ctrl.regWrite = 1'b1;
            end
            OP_LW: begin
                w_dec.in2           = w_imm;
                w_dec.writeReg      = REG_AW'(instr[20:16]);
                w_dec.ctrl.memRead  = 1'b1;
                w_dec.ctrl.memToReg = 1'b1;
                w_dec.ctrl.regWrite = 1'b1;
            end
            OP_SW: begin
                w_dec.in2           = w_imm;
                w_dec.storeData     = rtData;
                w_dec.ctrl.memWrite = 1'b1;
            end
            OP_BEQ: begin
                w_dec.aluOp         = ALUOP_SUB;
                w_dec.in2           = rtData;
                w_dec.ctrl.branch   = 1'b1;
            end
            OP_ADDI: begin
                w_dec.in2           = w_imm;
                w_dec.writeReg      = REG_AW'(instr[20:16]);
                w_dec.ctrl.regWrite = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        // Writes to $0 are architecturally discarded
        if (w_dec.writeReg == '0) begin
            w_dec.ctrl.regWrite = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
`ifdef HAZARD_DETECT_EN
    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .ex_valid_i    (ex_q.valid),
        .ex_memRead_i  (ex_q.ctrl.memRead),
        .ex_writeReg_i (ex_q.writeReg),
        .rs_i          (REG_AW'(instr[25:21])),
        .rt_i          (REG_AW'(instr[20:16])),
        .rtIsSrc_i     (op_reads_rt(w_op)),
        .instrValid_i  (instrValid),
        .hazard_o      (w_hazard)
    );
`else
    // Software schedules load delay slots; rs field has no other consumer
    logic w_unused_rs;
    assign w_hazard    = 1'b0;
    assign w_unused_rs = ^instr[25:21];
`endif

    assign stallOut = exHold | w_hazard;

    // The ID instruction actually leaves ID this cycle
    assign w_consume = ~flush & ~exHold & ~w_hazard & instrValid;

    // ------------------------------------------------------------------
    // ID/EX next state: flush > hold > hazard > bubble/illegal > load
    // ------------------------------------------------------------------
    always_comb begin
        ex_d     = ex_q;
        illCnt_d = illCnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (exHold) begin
            ex_d = ex_q;
        end else if (w_hazard || !instrValid || !w_legal) begin
            ex_d = '0;
        end else begin
            ex_d = w_dec;
        end
        if (w_consume && !w_legal && (illCnt_q != '1)) begin
            illCnt_d = illCnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q     <= '0;
            illCnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            illCnt_q <= illCnt_d;
        end
    end

    assign ex_valid         = ex_q.valid;
    assign ex_aluOp         = ex_q.aluOp;
    assign ex_function_code = ex_q.funct;
    assign ex_in1           = ex_q.in1;
    assign ex_in2           = ex_q.in2;
    assign ex_storeData     = ex_q.storeData;
    assign ex_writeReg      = ex_q.writeReg;
    assign ex_regWrite      = ex_q.ctrl.regWrite;
    assign ex_memRead       = ex_q.ctrl.memRead;
    assign ex_memWrite      = ex_q.ctrl.memWrite;
    assign ex_memToReg      = ex_q.ctrl.memToReg;
    assign ex_branch        = ex_q.ctrl.branch;
    assign illegalCount     = illCnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_decode.sv
`default_nettype none
// ============================================================================
//  Module  : tb_id_ex_decode
//  Purpose : Self-checking bench for id_ex_decode. A behavioural model of the
//            ID/EX register is updated every rising edge; a compare process
//            checks every DUT output against it on each falling edge. Directed
//            scenarios pin the model with literal expectations, followed by
//            randomized traffic.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_id_ex_decode;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [31:0]   instr;
    logic          instrValid;
    logic [DW-1:0] rsData, rtData;
    logic          flush, exHold;
    logic          stallOut, ex_valid;
    logic [1:0]    ex_aluOp;
    logic [5:0]    ex_function_code;
    logic [DW-1:0] ex_in1, ex_in2, ex_storeData;
    logic [AW-1:0] ex_writeReg;
    logic          ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_branch;
    logic [CW-1:0] illegalCount;

    id_ex_decode #(.DATA_WIDTH(DW), .REG_AW(AW), .ILL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid),
        .rsData(rsData), .rtData(rtData), .flush(flush), .exHold(exHold),
        .stallOut(stallOut), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
        .ex_function_code(ex_function_code), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_storeData(ex_storeData), .ex_writeReg(ex_writeReg),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_branch(ex_branch), .illegalCount(illegalCount)
    );

    // Behavioural model of the ID/EX register contents
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_br;
    logic [1:0]  m_aluOp;
    logic [5:0]  m_funct;
    logic [31:0] m_in1, m_in2, m_store;
    logic [4:0]  m_wr;
    int          m_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0;
        m_aluOp = 0; m_funct = 0; m_in1 = 0; m_in2 = 0; m_store = 0; m_wr = 0;
    endtask

    function automatic bit m_hazard();
`ifdef HAZARD_DETECT_EN
        logic [5:0] op    = instr[31:26];
        logic [4:0] rs    = instr[25:21];
        logic [4:0] rt    = instr[20:16];
        bit         rtsrc = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return instrValid && m_valid && m_mr && (m_wr != 0) &&
               ((m_wr == rs) || (rtsrc && (m_wr == rt)));
`else
        return 1'b0;
`endif
    endfunction

    // What the pipeline register must hold after this edge
    task automatic m_edge();
        bit          legal;
        logic [5:0]  op;
        logic [31:0] imm;
        if (reset) begin
            m_clear();
            m_cnt = 0;
            return;
        end
        op    = instr[31:26];
        imm   = {{16{instr[15]}}, instr[15:0]};
        legal = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
        if (flush) begin
            m_clear();
        end else if (exHold) begin
            // register keeps its contents
        end else if (m_hazard() || !instrValid) begin
            m_clear();
        end else if (!legal) begin
            m_clear();
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_clear();
            m_valid = 1;
            m_in1   = rsData;
            case (op)
                6'h00:   begin m_aluOp = 2; m_funct = instr[5:0]; m_in2 = rtData; m_wr = instr[15:11]; m_rw = 1; end
                6'h23:   begin m_in2 = imm; m_wr = instr[20:16]; m_mr = 1; m_m2r = 1; m_rw = 1; end
                6'h2B:   begin m_in2 = imm; m_mw = 1; m_store = rtData; end
                6'h04:   begin m_aluOp = 1; m_in2 = rtData; m_br = 1; end
                default: begin m_in2 = imm; m_wr = instr[20:16]; m_rw = 1; end
            endcase
            if (m_wr == 0) m_rw = 0;
        end
    endtask

    // Compare process: all outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("stallOut",     32'(stallOut),         32'(exHold | m_hazard()));
            check("ex_valid",     32'(ex_valid),         32'(m_valid));
            check("ex_aluOp",     32'(ex_aluOp),         32'(m_aluOp));
            check("ex_funct",     32'(ex_function_code), 32'(m_funct));
            check("ex_in1",       ex_in1,                m_in1);
            check("ex_in2",       ex_in2,                m_in2);
            check("ex_storeData", ex_storeData,          m_store);
            check("ex_writeReg",  32'(ex_writeReg),      32'(m_wr));
            check("ex_regWrite",  32'(ex_regWrite),      32'(m_rw));
            check("ex_memRead",   32'(ex_memRead),       32'(m_mr));
            check("ex_memWrite",  32'(ex_memWrite),      32'(m_mw));
            check("ex_memToReg",  32'(ex_memToReg),      32'(m_m2r));
            check("ex_branch",    32'(ex_branch),        32'(m_br));
            check("illegalCount", 32'(illegalCount),     32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        m_clear();
        m_cnt = 0;
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        instr = i; instrValid = 1'b1; rsData = rs; rtData = rt;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legal_ops [5];
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};

        reset = 1'b1; instr = '0; instrValid = 1'b0; rsData = '0; rtData = '0;
        flush = 1'b0; exHold = 1'b0;
        m_clear(); m_cnt = 0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_valid", 32'(ex_valid),     32'd0);
        check("reset_in2",   ex_in2,            32'd0);
        check("reset_cnt",   32'(illegalCount), 32'd0);
        check("reset_stall", 32'(stallOut),     32'd0);
        reset = 1'b0;

        // add $3,$1,$2
        drive(32'h00221820, 32'd5, 32'd7);
        tick();
        check("add_aluOp", 32'(ex_aluOp),         32'd2);
        check("add_funct", 32'(ex_function_code), 32'h20);
        check("add_in1",   ex_in1,                32'd5);
        check("add_in2",   ex_in2,                32'd7);
        check("add_wr",    32'(ex_writeReg),      32'd3);
        check("add_rw",    32'(ex_regWrite),      32'd1);

        // lw $4,-4($1) then add $5,$4,$2
        drive(32'h8C24FFFC, 32'd100, 32'd0);
        tick();
        check("lw_in2", ex_in2, 32'hFFFF_FFFC);
        drive(32'h00822820, 32'd11, 32'd22);
        #1;
`ifdef HAZARD_DETECT_EN
        check("lu_stall", 32'(stallOut), 32'd1);
        tick();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        tick();
`else
        check("lu_stall", 32'(stallOut), 32'd0);
        tick();
`endif
        check("lu_add_valid", 32'(ex_valid),    32'd1);
        check("lu_add_wr",    32'(ex_writeReg), 32'd5);

        // downstream hold with new instructions arriving, then flush during hold
        exHold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(32'h20270000 + 32'(k), 32'(k), 32'(k));
            tick();
            check("hold_wr",    32'(ex_writeReg), 32'd5);
            check("hold_stall", 32'(stallOut),    32'd1);
        end
        flush = 1'b1;
        tick();
        check("flush_hold", 32'(ex_valid), 32'd0);
        flush = 1'b0; exHold = 1'b0;

        // illegal opcode saturation
        drive(32'hFC000000, 32'd1, 32'd2);
        repeat (300) tick();
        check("ill_sat",   32'(illegalCount), 32'd255);
        check("ill_bubble", 32'(ex_valid),    32'd0);
        assert_reset();
        check("ill_rst", 32'(illegalCount), 32'd0);
        tick();
        reset = 1'b0;

        // addi $0,$1,1 ; beq $1,$2,8 ; then reset mid-stream
        drive(32'h20200001, 32'd3, 32'd4);
        tick();
        check("addi0_valid", 32'(ex_valid),    32'd1);
        check("addi0_rw",    32'(ex_regWrite), 32'd0);
        check("addi0_in2",   ex_in2,           32'd1);
        drive(32'h10220008, 32'd3, 32'd9);
        tick();
        check("beq_aluOp",  32'(ex_aluOp),  32'd1);
        check("beq_branch", 32'(ex_branch), 32'd1);
        check("beq_in2",    ex_in2,         32'd9);
        assert_reset();
        check("midrst_valid", 32'(ex_valid),  32'd0);
        check("midrst_in1",   ex_in1,         32'd0);
        check("midrst_br",    32'(ex_branch), 32'd0);
        tick();
        reset = 1'b0;

        // randomized traffic with small register numbers to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
            end else begin
                reset = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08});
            end else begin
                op = legal_ops[$urandom_range(0, 4)];
            end
            instr      = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 11'($urandom)};
            instrValid = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            exHold     = ($urandom_range(0, 6) == 0);
            rsData     = $urandom;
            rtData     = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
